gtxe2_chnl_rx_des_align: RTL and testbench



---
 rtl/gtxe2_chnl_rx_des_align_pkg.sv | 16 +
 rtl/gtxe2_chnl_rx_des_align_if.sv | 23 ++
 rtl/gtxe2_chnl_rx_comma_det.sv | 15 +
 rtl/gtxe2_chnl_rx_des_align.sv | 102 ++++++++++
 tb/tb_gtxe2_chnl_rx_des_align.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/gtxe2_chnl_rx_des_align_pkg.sv
// Shared constants for the GTXE2 RX deserializer model: K28.5 comma patterns and the trim ratio.
package gtxe2_chnl_rx_des_align_pkg;

    localparam int         K28_LEN   = 10;
    // First-received bit sits in bit 0 of each pattern.
    localparam logic [9:0] K28_5_RDM = 10'b0101111100;
    localparam logic [9:0] K28_5_RDP = 10'b1010000011;

    localparam int TRIM_NUM = 4;
    localparam int TRIM_DEN = 5;

    function automatic int trim_len(input int w);
        return w * TRIM_NUM / TRIM_DEN;
    endfunction

endpackage

// File: rtl/gtxe2_chnl_rx_des_align_if.sv
// Serial-in / parallel-out bundle between the RX sampler model and the deserializer.
interface gtxe2_chnl_rx_des_align_if #(parameter int width = 20);

    logic             indata;
    logic             trim;
    logic             bitslip;
    logic             comma_en;
    logic [width-1:0] outdata;
    logic             outval;
    logic             comma_det;
    logic             aligned;

    modport master (
        output indata, trim, bitslip, comma_en,
        input  outdata, outval, comma_det, aligned
    );

    modport slave (
        input  indata, trim, bitslip, comma_en,
        output outdata, outval, comma_det, aligned
    );

endinterface

// File: rtl/gtxe2_chnl_rx_comma_det.sv
// Combinational dual-polarity comma matcher over a comma_len-bit window.
module gtxe2_chnl_rx_comma_det
    import gtxe2_chnl_rx_des_align_pkg::*;
#(
    parameter int                   comma_len = K28_LEN,
    parameter logic [comma_len-1:0] comma_p   = K28_5_RDM,
    parameter logic [comma_len-1:0] comma_m   = K28_5_RDP
) (
    input  logic [comma_len-1:0] win,
    output logic                 hit
);

    assign hit = (win == comma_p) || (win == comma_m);

endmodule

// File: rtl/gtxe2_chnl_rx_des_align.sv
// Bit-clock deserializer with 4/5 trim, bitslip and automatic comma alignment.
module gtxe2_chnl_rx_des_align
    import gtxe2_chnl_rx_des_align_pkg::*;
#(
    parameter int                   width         = 20,
    parameter int                   comma_len     = K28_LEN,
    parameter logic [comma_len-1:0] comma_p       = K28_5_RDM,
    parameter logic [comma_len-1:0] comma_m       = K28_5_RDP,
    parameter bit                   comma_realign = 1'b1
) (
    input logic                         inclk,
    input logic                         reset,
    gtxe2_chnl_rx_des_align_if.slave    rx
);

    localparam int len_trim = trim_len(width);
    localparam int cw       = $clog2(width + 1);

    // The oldest bit is shifted out before anyone reads it, so only width-1 bits are stored.
    logic [width-1:1] sr;
    logic [width-1:0] sr_nxt;
    logic [width-1:0] cap;
    logic [cw-1:0]    cnt;
    logic [cw-1:0]    cnt_nxt;
    logic [cw-1:0]    len_m1;
    logic             trim_q;
    logic             comma_en_q;
    logic             aligned_q;
    logic             live_hit;
    logic             cap_hit;
    logic             realign;
    logic             slip;
    logic             wrap;
    logic             capture;

    assign sr_nxt  = {rx.indata, sr};
    assign len_m1  = trim_q ? cw'(len_trim - 1) : cw'(width - 1);
    assign wrap    = (cnt == len_m1);
    assign realign = live_hit && rx.comma_en && (!aligned_q || comma_realign);
    assign slip    = rx.bitslip && !realign;
    // A slip on the last bit holds the counter, so that word completes one cycle later.
    assign capture = wrap && !slip;
    assign cap     = trim_q ? (sr_nxt >> (width - len_trim)) : sr_nxt;

    always_comb begin
        cnt_nxt = cnt + cw'(1);
        if (realign)
            cnt_nxt = cw'(comma_len);
        else if (slip)
            cnt_nxt = cnt;
        else if (wrap)
            cnt_nxt = '0;
    end

    gtxe2_chnl_rx_comma_det #(
        .comma_len (comma_len),
        .comma_p   (comma_p),
        .comma_m   (comma_m)
    ) u_live_det (
        .win (sr_nxt[width-1 -: comma_len]),
        .hit (live_hit)
    );

    gtxe2_chnl_rx_comma_det #(
        .comma_len (comma_len),
        .comma_p   (comma_p),
        .comma_m   (comma_m)
    ) u_cap_det (
        .win (cap[comma_len-1:0]),
        .hit (cap_hit)
    );

    always_ff @(posedge inclk) begin
        if (reset) begin
            sr           <= '0;
            cnt          <= '0;
            trim_q       <= rx.trim;
            comma_en_q   <= 1'b0;
            aligned_q    <= 1'b0;
            rx.outdata   <= '0;
            rx.outval    <= 1'b0;
            rx.comma_det <= 1'b0;
        end else begin
            sr         <= sr_nxt[width-1:1];
            cnt        <= cnt_nxt;
            comma_en_q <= rx.comma_en;
            rx.outval  <= capture;
            if (capture) begin
                rx.outdata   <= cap;
                rx.comma_det <= cap_hit;
                trim_q       <= rx.trim;
            end
            if (realign)
                aligned_q <= 1'b1;
            else if (slip || (comma_en_q && !rx.comma_en))
                aligned_q <= 1'b0;
        end
    end

    assign rx.aligned = aligned_q;

endmodule

// File: tb/tb_gtxe2_chnl_rx_des_align.sv
// Directed + random bench; two DUTs (realign on / lock) against a bit-queue word model.
module tb_gtxe2_chnl_rx_des_align;

    localparam int         W  = 20;
    localparam int         LT = 16;
    localparam int         CL = 10;
    localparam logic [9:0] CP = 10'b0101111100;
    localparam logic [9:0] CM = 10'b1010000011;

    logic inclk = 1'b0;
    logic reset;
    always #5 inclk = ~inclk;

    gtxe2_chnl_rx_des_align_if #(.width(W)) ifa ();
    gtxe2_chnl_rx_des_align_if #(.width(W)) ifb ();

    gtxe2_chnl_rx_des_align #(.width(W), .comma_len(CL), .comma_p(CP), .comma_m(CM),
                              .comma_realign(1'b1))
        dut (.inclk(inclk), .reset(reset), .rx(ifa));

    gtxe2_chnl_rx_des_align #(.width(W), .comma_len(CL), .comma_p(CP), .comma_m(CM),
                              .comma_realign(1'b0))
        dut_lock (.inclk(inclk), .reset(reset), .rx(ifb));

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    bit          rs, sl, tr, ce, rnd;
    logic [31:0] pat;
    int          plen, pidx;
    bit          sq[$];

    // Model: each DUT's current word is the list of bits received since its boundary.
    logic [63:0] hist;
    logic [31:0] wbits[2];
    int          wcnt[2];
    bit          mal[2], mtrq[2], eov[2], ecd[2], prev_en;
    logic [19:0] eod[2];

    logic [19:0] dod[2];
    bit          dov[2], dcd[2], dal[2];
    int          last_sb[2], gap[2];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic push_bits(input logic [31:0] v, input int n);
        for (int i = 0; i < n; i++) sq.push_back(v[i]);
    endtask

    task automatic model_update(input bit d);
        logic [9:0] win;
        bit         match, ra;
        int         l;
        if (rs) begin
            hist    = '0;
            prev_en = 1'b0;
            for (int m = 0; m < 2; m++) begin
                wbits[m] = '0; wcnt[m] = 0; mal[m] = 1'b0; mtrq[m] = tr;
                eod[m] = '0; eov[m] = 1'b0; ecd[m] = 1'b0;
            end
            return;
        end
        hist = {hist[62:0], d};
        for (int i = 0; i < CL; i++) win[i] = hist[CL-1-i];
        match = (win == CP) || (win == CM);
        for (int m = 0; m < 2; m++) begin
            ra = match && ce && (!mal[m] || m == 0);
            wbits[m][wcnt[m]] = d;
            wcnt[m]++;
            if (sl && !ra) begin
                wbits[m] = wbits[m] >> 1;
                wcnt[m]--;
                mal[m] = 1'b0;
            end
            eov[m] = 1'b0;
            l = mtrq[m] ? LT : W;
            if (wcnt[m] == l) begin
                eod[m]  = wbits[m][19:0];
                ecd[m]  = (wbits[m][9:0] == CP) || (wbits[m][9:0] == CM);
                eov[m]  = 1'b1;
                mtrq[m] = tr;
                wbits[m] = '0;
                wcnt[m]  = 0;
            end
            if (ra) begin
                wbits[m] = {22'b0, win};
                wcnt[m]  = CL;
                mal[m]   = 1'b1;
            end
            if (prev_en && !ce) mal[m] = 1'b0;
        end
        prev_en = ce;
    endtask

    task automatic step();
        bit d;
        @(negedge inclk);
        if (sq.size() > 0) d = sq.pop_front();
        else if (rnd) d = 1'($urandom);
        else begin
            d = pat[pidx];
            pidx = (pidx + 1) % plen;
        end
        reset = rs;
        ifa.indata = d; ifa.trim = tr; ifa.bitslip = sl; ifa.comma_en = ce;
        ifb.indata = d; ifb.trim = tr; ifb.bitslip = sl; ifb.comma_en = ce;
        @(posedge inclk);
        model_update(d);
        #1;
        dod[0] = ifa.outdata; dov[0] = ifa.outval; dcd[0] = ifa.comma_det; dal[0] = ifa.aligned;
        dod[1] = ifb.outdata; dov[1] = ifb.outval; dcd[1] = ifb.comma_det; dal[1] = ifb.aligned;
        for (int m = 0; m < 2; m++) begin
            check($sformatf("outdata[%0d]", m),   32'(dod[m]), 32'(eod[m]));
            check($sformatf("outval[%0d]", m),    32'(dov[m]), 32'(eov[m]));
            check($sformatf("comma_det[%0d]", m), 32'(dcd[m]), 32'(ecd[m]));
            check($sformatf("aligned[%0d]", m),   32'(dal[m]), 32'(mal[m]));
        end
        cyc++;
        for (int m = 0; m < 2; m++)
            if (dov[m]) begin
                gap[m]     = cyc - last_sb[m];
                last_sb[m] = cyc;
            end
        sl = 1'b0;
    endtask

    task automatic wait_strobe(input int m, input int maxc);
        int n = 0;
        do begin
            step();
            n++;
        end while (!dov[m] && n < maxc);
        check($sformatf("strobe_seen[%0d]", m), 32'(dov[m]), 32'd1);
    endtask

    initial begin
        reset = 1'b1;
        ifa.indata = 0; ifa.trim = 0; ifa.bitslip = 0; ifa.comma_en = 0;
        ifb.indata = 0; ifb.trim = 0; ifb.bitslip = 0; ifb.comma_en = 0;
        rs = 1; tr = 0; ce = 0; sl = 0; rnd = 0;
        pat = 32'hAAAA_AAAA; plen = 2; pidx = 0;
        last_sb = '{0, 0}; gap = '{0, 0};

        // Reset with a toggling serial input
        repeat (5) begin
            step();
            check("rst_outval",  32'(dov[0]), 32'd0);
            check("rst_outdata", 32'(dod[0]), 32'd0);
            check("rst_aligned", 32'(dal[0]), 32'd0);
        end

        // Full-width capture
        rs = 0; pat = 32'h5A5A5; plen = 20; pidx = 0;
        repeat (20) step();
        check("full_val",  32'(dov[0]), 32'd1);
        check("full_word", 32'(dod[0]), 32'h5A5A5);
        wait_strobe(0, 25);
        check("full_period", 32'(gap[0]), 32'd20);
        check("full_word2",  32'(dod[0]), 32'h5A5A5);

        // Trimmed capture; a mid-word trim drop only applies to the following word
        rs = 1; tr = 1; repeat (2) step();
        rs = 0; pat = 32'hBEEF; plen = 16; pidx = 0;
        repeat (16) step();
        check("trim_val",  32'(dov[0]), 32'd1);
        check("trim_word", 32'(dod[0]), 32'h0BEEF);
        repeat (5) step();
        tr = 0;
        wait_strobe(0, 25);
        check("trim_hold_period", 32'(gap[0]), 32'd16);
        check("trim_hold_word",   32'(dod[0]), 32'h0BEEF);
        pat = 32'h5A5A5; plen = 20; pidx = 0;
        wait_strobe(0, 25);
        check("untrim_period", 32'(gap[0]), 32'd20);
        check("untrim_word",   32'(dod[0]), 32'h5A5A5);

        // Bitslip mid-word: one long period, then words rotated by one bit
        repeat (7) step();
        sl = 1; step();
        wait_strobe(0, 30);
        check("slip_period", 32'(gap[0]), 32'd21);
        check("slip_word",   32'(dod[0]), 32'hAD2D2);
        wait_strobe(0, 30);
        check("post_slip_period", 32'(gap[0]), 32'd20);
        check("post_slip_word",   32'(dod[0]), 32'hAD2D2);

        // RD- comma at offset 7
        rs = 1; ce = 1; repeat (2) step();
        rs = 0; pat = 32'h5A5A5; plen = 20; pidx = 0;
        push_bits(32'h0, 7); push_bits(32'(CP), 10); push_bits(32'h155, 10);
        repeat (17) step();
        check("align_p",      32'(dal[0]), 32'd1);
        check("align_p_lock", 32'(dal[1]), 32'd1);
        repeat (10) step();
        check("comma_p_val",  32'(dov[0]), 32'd1);
        check("comma_p_word", 32'(dod[0][9:0]), 32'(CP));
        check("comma_p_det",  32'(dcd[0]), 32'd1);

        // Comma three bits off the current boundary: lock keeps it, realign moves it
        push_bits(32'h5, 3); push_bits(32'(CP), 10); push_bits(32'h155, 10);
        repeat (13) step();
        check("lock_aligned",    32'(dal[1]), 32'd1);
        check("realign_aligned", 32'(dal[0]), 32'd1);
        wait_strobe(1, 25);
        check("lock_period", 32'(gap[1]), 32'd20);
        wait_strobe(0, 25);
        check("realign_period", 32'(gap[0]), 32'd23);
        check("realign_word",   32'(dod[0][9:0]), 32'(CP));
        check("realign_det",    32'(dcd[0]), 32'd1);

        // Bitslip on the cycle of an aligned comma
        push_bits(32'(CP), 9);
        repeat (9) step();
        push_bits(32'(CP >> 9), 1);
        sl = 1; step();
        check("slip_comma_aligned", 32'(dal[0]), 32'd1);
        check("slip_lock_cleared",  32'(dal[1]), 32'd0);
        wait_strobe(0, 25);
        check("slip_comma_period", 32'(gap[0]), 32'd20);
        check("slip_comma_det",    32'(dcd[0]), 32'd1);

        // RD+ comma at offset 7, then comma_en fall
        rs = 1; repeat (2) step();
        rs = 0;
        push_bits(32'h7F, 7); push_bits(32'(CM), 10); push_bits(32'h2AA, 10);
        repeat (17) step();
        check("align_m", 32'(dal[0]), 32'd1);
        repeat (10) step();
        check("comma_m_val",  32'(dov[0]), 32'd1);
        check("comma_m_word", 32'(dod[0][9:0]), 32'(CM));
        check("comma_m_det",  32'(dcd[0]), 32'd1);
        ce = 0; step();
        check("en_fall_clear", 32'(dal[0]), 32'd0);

        // Random traffic with injected commas, slips, trim and enable changes
        rnd = 1; ce = 1; rs = 1; step();
        rs = 0;
        for (int k = 0; k < 4000; k++) begin
            rs = ($urandom_range(0, 599) == 0);
            sl = ($urandom_range(0, 49) == 0);
            if ($urandom_range(0, 149) == 0) tr = !tr;
            if ($urandom_range(0, 299) == 0) ce = !ce;
            if (sq.size() == 0 && $urandom_range(0, 24) == 0)
                push_bits($urandom_range(0, 1) ? 32'(CM) : 32'(CP), 10);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
